data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit words; 4*DEPTH_WORDS SHALL NOT exceed 256.
REQ-002 SHALL have parameter WAIT_STATES, default 2, legal range 0..15: extra cycles between request accept and memory access.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request this cycle.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 8: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port req_funct3, input, 3: RISC-V load/store width code.
REQ-011 SHALL have port rsp_valid, output, 1: response available.
REQ-012 SHALL have port rsp_ready, input, 1: initiator consumes the response.
REQ-013 SHALL have port rsp_rdata, output, 32: load result, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1: misaligned or illegal request.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = (state == IDLE).
REQ-017 SHALL accept on a clock edge where req_valid && req_ready, latching write, addr, wdata and funct3; later input changes SHALL be ignored.
REQ-018 SHALL load the wait counter with WAIT_STATES on accept, decrement it each WAIT cycle, and leave WAIT when it reaches 0; WAIT_STATES=0 SHALL spend exactly one WAIT cycle.
REQ-019 SHALL perform the array access on the WAIT->RESP edge, then assert rsp_valid; rsp_valid SHALL first be high WAIT_STATES+1 cycles after the accept edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready=1, then return to IDLE with rsp_valid=0; no back-to-back accept on that same edge.
REQ-021 SHALL decode loads as: 000 LB and 001 LH sign-extended, 010 LW, 100 LBU and 101 LHU zero-extended; little-endian byte lanes selected by addr[1:0].
REQ-022 SHALL decode stores as: 000 SB, 001 SH, 010 SW; only the addressed byte lanes are written.
REQ-023 SHALL index the word as addr[7:2] modulo DEPTH_WORDS (wrap-around, no error).
REQ-024 SHALL treat as misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-025 SHALL treat as illegal: load funct3 011/110/111, store funct3 other than 000/001/010.
REQ-026 SHALL NOT modify memory for a misaligned or illegal store.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0; req_ready SHALL be 1 after reset release.
REQ-028 SHALL discard any accepted but uncommitted request (including a store in WAIT) when reset asserts mid-operation.
REQ-029 SHALL NOT clear memory array contents on reset.

Configuration
REQ-030 SHALL, with macro DMEM_RESP_ERR_EN defined, detect per REQ-024/025, return rsp_err=1 with rsp_rdata=0, and suppress the access.
REQ-031 SHALL, without DMEM_RESP_ERR_EN, tie rsp_err to 0, force misaligned addresses aligned by ignoring addr[0] (halfword) or addr[1:0] (word), and treat illegal funct3 as LW/SW.

Verification
REQ-032 SHALL cover: reset, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after each accept with WAIT_STATES=2.
REQ-033 SHALL cover: after REQ-032 data, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-034 SHALL cover: SB 0x11 data 0x00000055 onto 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
REQ-035 SHALL cover: with DMEM_RESP_ERR_EN, SW addr 0x12 -> rsp_err=1, rsp_rdata=0, and a following LW 0x10 returns unchanged data.
REQ-036 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready=0 and new req_valid ignored throughout.
REQ-037 SHALL cover: reset asserted during WAIT of SW 0x20 data 0x12345678 -> after release, state IDLE, and LW 0x20 returns the pre-store value.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port data memory responder with a valid/ready request and response handshake.
// Optional macro DMEM_RESP_ERR_EN: flag misaligned/illegal accesses instead of forcing alignment.
package data_mem_responder_pkg;

  typedef struct packed {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } mem_req_t;

endpackage

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mem_req_t           req_q, req_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               illegal_c, misalign_c, err_c;
  logic               is_word_c, is_half_c;
  logic [7:0]         eff_addr_c;
  logic [1:0]         lane_c;
  logic [5:0]         word_c;
  logic [IDX_W-1:0]   idx_c;
  logic [31:0]        rd_word_c, rd_shift_c, load_c;
  logic [31:0]        wr_data_c;
  logic [3:0]         be_c;
  logic               commit_c, mem_we_c;

  // Decode the latched request into size, alignment, lane and error flags.
  always_comb begin
    illegal_c  = 1'b0;
    is_word_c  = 1'b0;
    is_half_c  = 1'b0;
    misalign_c = 1'b0;
    err_c      = 1'b0;
    eff_addr_c = req_q.addr;

    if (req_q.write) begin
      illegal_c = req_q.funct3[2] | (req_q.funct3[1:0] == 2'b11);
    end else begin
      illegal_c = (req_q.funct3 == 3'b011) | (req_q.funct3[2:1] == 2'b11);
    end
    // Illegal codes fall back to full-word handling when errors are not reported.
    is_word_c  = illegal_c | (req_q.funct3[1:0] == 2'b10);
    is_half_c  = !illegal_c && (req_q.funct3[1:0] == 2'b01);
    misalign_c = (is_half_c & req_q.addr[0]) | (is_word_c & (req_q.addr[1:0] != 2'b00));

`ifdef DMEM_RESP_ERR_EN
    err_c      = illegal_c | misalign_c;
`else
    err_c      = 1'b0;
    if (is_word_c) begin
      eff_addr_c = {req_q.addr[7:2], 2'b00};
    end else if (is_half_c) begin
      eff_addr_c = {req_q.addr[7:1], 1'b0};
    end
`endif
  end

  // Word index with wrap-around, and little-endian lane steering for both directions.
  always_comb begin
    lane_c     = eff_addr_c[1:0];
    word_c     = eff_addr_c[7:2];
    idx_c      = IDX_W'(32'(word_c) % DEPTH_WORDS);
    rd_word_c  = mem[idx_c];
    rd_shift_c = rd_word_c >> {lane_c, 3'b000};
    load_c     = rd_shift_c;
    if (!is_word_c) begin
      if (is_half_c) begin
        load_c = {{16{rd_shift_c[15] & ~req_q.funct3[2]}}, rd_shift_c[15:0]};
      end else begin
        load_c = {{24{rd_shift_c[7] & ~req_q.funct3[2]}}, rd_shift_c[7:0]};
      end
    end

    wr_data_c = req_q.wdata << {lane_c, 3'b000};
    if (is_word_c) begin
      be_c = 4'b1111;
    end else if (is_half_c) begin
      be_c = 4'b0011 << lane_c;
    end else begin
      be_c = 4'b0001 << lane_c;
    end

    commit_c = (state_q == S_WAIT) && (cnt_q == '0);
    mem_we_c = commit_c && req_q.write && !err_c;
  end

  // Array is never reset; writes land on the WAIT->RESP edge only.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) begin
          mem[idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d.write  = req_write;
          req_d.addr   = req_addr;
          req_d.wdata  = req_wdata;
          req_d.funct3 = req_funct3;
          cnt_d        = CNT_W'(WAIT_STATES);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          rsp_rdata_d = (req_q.write || err_c) ? 32'h0 : load_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem_m [4*DEPTH];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: byte-granular memory, sizes from funct3, rules applied directly.
  function automatic void model(input bit w, input logic [7:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output bit er);
    int size, al, base;
    bit ill, mis;
    logic [31:0] v;
    ill  = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (ill) size = 4;
    mis = (int'(a) % size) != 0;
    rd = 32'h0;
    er = 1'b0;
`ifdef DMEM_RESP_ERR_EN
    if (ill || mis) begin
      er = 1'b1;
      return;
    end
`endif
    al   = int'(a) - (int'(a) % size);
    base = ((al / 4) % DEPTH) * 4 + (al % 4);
    if (w) begin
      for (int i = 0; i < size; i++) mem_m[base+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(mem_m[base+i]) << (8*i));
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  task automatic do_req(input bit w, input logic [7:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold, output logic [31:0] obs);
    logic [31:0] erd;
    bit eer;
    int lat;
    model(w, a, wd, f3, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_funct3 = f3;
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(req_ready), 32'd0);
    @(negedge clk);
    // Junk on the request bus must be ignored while busy.
    req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = 8'($urandom);
    req_wdata = $urandom; req_funct3 = 3'($urandom);
    lat = 1;
    @(posedge clk); #1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(WS + 1));
    chk("rdata", rsp_rdata, erd);
    chk("err", 32'(rsp_err), 32'(eer));
    obs = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 8'($urandom); req_write = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, erd);
      chk("hold_err", 32'(rsp_err), 32'(eer));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] obs, pre;
    bit pre_er;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Fill every word so the model and array agree.
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 8'(4*i), $urandom, 3'b010, 0, obs);

    do_req(1'b1, 8'h10, 32'hDEADBEEF, 3'b010, 0, obs);
    do_req(1'b0, 8'h10, 32'h0, 3'b010, 0, obs);
    chk("lw_10", obs, 32'hDEADBEEF);
    do_req(1'b0, 8'h13, 32'h0, 3'b000, 0, obs);
    chk("lb_13", obs, 32'hFFFFFFDE);
    do_req(1'b0, 8'h13, 32'h0, 3'b100, 0, obs);
    chk("lbu_13", obs, 32'h000000DE);
    do_req(1'b0, 8'h12, 32'h0, 3'b001, 0, obs);
    chk("lh_12", obs, 32'hFFFFDEAD);
    do_req(1'b0, 8'h10, 32'h0, 3'b101, 0, obs);
    chk("lhu_10", obs, 32'h0000BEEF);
    do_req(1'b1, 8'h11, 32'h00000055, 3'b000, 0, obs);
    do_req(1'b0, 8'h10, 32'h0, 3'b010, 0, obs);
    chk("lw_after_sb", obs, 32'hDEAD55EF);

    // Misaligned store: flagged or force-aligned depending on build.
    do_req(1'b1, 8'h12, 32'hCAFEF00D, 3'b010, 0, obs);
    do_req(1'b0, 8'h10, 32'h0, 3'b010, 0, obs);
`ifdef DMEM_RESP_ERR_EN
    chk("lw_after_bad_sw", obs, 32'hDEAD55EF);
`else
    chk("lw_after_aligned_sw", obs, 32'hCAFEF00D);
`endif

    // Back-pressure with competing requests.
    do_req(1'b0, 8'h10, 32'h0, 3'b010, 5, obs);

    // Reset during WAIT of a store discards it.
    model(1'b0, 8'h20, 32'h0, 3'b010, pre, pre_er);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    chk("midrst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 8'h20, 32'h0, 3'b010, 0, obs);
    chk("lw_20_unchanged", obs, pre);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      do_req(1'($urandom), 8'($urandom), $urandom, 3'($urandom), int'($urandom_range(0, 3)), obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
